sprite_anim_rom: RTL and testbench

//  Parametrised, animated sprite pixel source for the gameplay layer. Receives the
//  VGA scan coordinate each clk and returns the sprite colour, an opaque flag and a

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_rom_sync.sv | 30 +++
 rtl/sprite_anim_rom.sv | 178 +++++++++++++++++
 tb/tb_sprite_anim_rom.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, animation state encoding and the procedural sprite art for the sprite source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int COLOR_W  = 12;
    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [COLOR_W-1:0] TRANSP_KEY_DEF = 12'hF0F;

    typedef enum logic [1:0] {
        ANIM_IDLE = 2'd0,
        ANIM_PLAY = 2'd1,
        ANIM_HOLD = 2'd2
    } anim_state_t;

    // Word = its own address, except one transparent pixel and a green neighbour at (10,10)/(11,10) of every frame.
    function automatic logic [31:0] sprite_art(input int unsigned addr, input int unsigned frame_words,
                                               input int unsigned row_w, input logic [31:0] key);
        int unsigned ofs;
        ofs = addr % frame_words;
        if (ofs == 10 * row_w + 10) begin
            return key;
        end else if (ofs == 10 * row_w + 11) begin
            return 32'h0000_00F0;
        end
        return addr;
    endfunction

endpackage

// File: rtl/sprite_rom_sync.sv
// Single-port sprite ROM with a registered read port; contents are the constant sprite art table.
// Latency: 1 clk from addr to rd_dat.
// Backpressure: none, one read per cycle.
module sprite_rom_sync
    import sprite_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WIDTH       = 12,
    parameter int FRAME_WORDS = 1024,
    parameter int ROW_W       = 32,
    parameter logic [WIDTH-1:0] KEY = 12'hF0F,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] rom_tbl [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_word
        assign rom_tbl[a] = WIDTH'(sprite_art(a, FRAME_WORDS, ROW_W, 32'(KEY)));
    end

    // No reset on the read register so the table maps onto block ROM.
    always_ff @(posedge clk) begin
        rd_dat <= rom_tbl[addr];
    end

endmodule

// File: rtl/sprite_anim_rom.sv
// Animated sprite pixel source: scan coordinate in, colour/opaque/valid out; SPRITE_FLIP_EN adds horizontal mirroring.
// Latency: fixed 2 clk from pix_* to color_out/opaque/out_valid.
// Backpressure: none, accepts one pixel every clk.
module sprite_anim_rom
    import sprite_pkg::*;
#(
    parameter int SPR_W        = 32,
    parameter int SPR_H        = 32,
    parameter int NUM_FRAMES   = 4,
    parameter int COLOR_W      = sprite_pkg::COLOR_W,
    parameter int TICKS_PER_FR = 8,
    parameter bit ONE_SHOT     = 1'b0,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = COLOR_W'(sprite_pkg::TRANSP_KEY_DEF),
    localparam int FR_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_valid,
    input  logic               vsync_tick,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               anim_start,
    input  logic               anim_stop,
    input  logic               flip_h,
    output logic [COLOR_W-1:0] color_out,
    output logic               opaque,
    output logic               out_valid,
    output logic [FR_W-1:0]    frame_idx
);

    localparam int FRAME_WORDS = SPR_W * SPR_H;
    localparam int DEPTH       = NUM_FRAMES * FRAME_WORDS;
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DX_W        = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int DY_W        = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int TK_W        = (TICKS_PER_FR > 1) ? $clog2(TICKS_PER_FR) : 1;
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICKS_PER_FR - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(NUM_FRAMES - 1);

    anim_state_t        anim_st;
    logic [TK_W-1:0]    tick_cnt;
    logic [FR_W-1:0]    frame_l;
    logic [COORD_W-1:0] pos_l_x;
    logic [COORD_W-1:0] pos_l_y;

    logic [COORD_W-1:0] s0_x;
    logic [COORD_W-1:0] s0_y;
    logic               s0_vld;
    logic [COORD_W:0]   dx;
    logic [COORD_W:0]   dy;
    logic               s0_hit;
    logic [DX_W-1:0]    dx_eff;
    logic [AW-1:0]      rom_addr;

    logic               s1_vld;
    logic               s1_hit;
    logic [COLOR_W-1:0] rom_q;

    // Placement only moves at frame start so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_l_x <= '0;
            pos_l_y <= '0;
        end else if (vsync_tick) begin
            pos_l_x <= pos_x;
            pos_l_y <= pos_y;
        end
    end

    // frame_l is what the pixel pipe renders; it takes the post-tick frame so a new frame appears on its own vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_st   <= ANIM_IDLE;
            tick_cnt  <= '0;
            frame_idx <= '0;
            frame_l   <= '0;
        end else begin
            if (vsync_tick) begin
                frame_l <= frame_idx;
            end
            if (anim_start) begin
                anim_st   <= ANIM_PLAY;
                tick_cnt  <= '0;
                frame_idx <= '0;
                if (vsync_tick) begin
                    frame_l <= '0;
                end
            end else if (anim_stop && anim_st != ANIM_IDLE) begin
                anim_st <= ANIM_IDLE;
            end else if (anim_st == ANIM_PLAY && vsync_tick) begin
                if (tick_cnt == TK_LAST) begin
                    tick_cnt <= '0;
                    if (frame_idx == FR_LAST) begin
                        if (ONE_SHOT) begin
                            anim_st <= ANIM_HOLD;
                        end else begin
                            frame_idx <= '0;
                            frame_l   <= '0;
                        end
                    end else begin
                        frame_idx <= frame_idx + FR_W'(1);
                        frame_l   <= frame_idx + FR_W'(1);
                    end
                end else begin
                    tick_cnt <= tick_cnt + TK_W'(1);
                end
            end
        end
    end

    // Zero-extended subtraction: a negative offset shows up as the MSB, so off-screen parts never wrap.
    assign dx = {1'b0, s0_x} - {1'b0, pos_l_x};
    assign dy = {1'b0, s0_y} - {1'b0, pos_l_y};

    assign s0_hit = s0_vld
                 && !dx[COORD_W] && (dx < (COORD_W + 1)'(SPR_W))
                 && !dy[COORD_W] && (dy < (COORD_W + 1)'(SPR_H))
                 && (s0_x < COORD_W'(SCREEN_W)) && (s0_y < COORD_W'(SCREEN_H));

`ifdef SPRITE_FLIP_EN
    logic flip_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_l <= 1'b0;
        end else if (vsync_tick) begin
            flip_l <= flip_h;
        end
    end

    assign dx_eff = flip_l ? DX_W'(SPR_W - 1) - dx[DX_W-1:0] : dx[DX_W-1:0];
`else
    logic unused_flip;

    assign unused_flip = flip_h;
    assign dx_eff      = dx[DX_W-1:0];
`endif

    assign rom_addr = AW'(frame_l) * AW'(FRAME_WORDS)
                    + AW'(dy[DY_W-1:0]) * AW'(SPR_W)
                    + AW'(dx_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_x   <= '0;
            s0_y   <= '0;
            s0_vld <= 1'b0;
            s1_vld <= 1'b0;
            s1_hit <= 1'b0;
        end else begin
            s0_x   <= pix_x;
            s0_y   <= pix_y;
            s0_vld <= pix_valid;
            s1_vld <= s0_vld;
            s1_hit <= s0_hit;
        end
    end

    sprite_rom_sync #(
        .DEPTH       (DEPTH),
        .WIDTH       (COLOR_W),
        .FRAME_WORDS (FRAME_WORDS),
        .ROW_W       (SPR_W),
        .KEY         (TRANSP_KEY)
    ) u_rom (
        .clk    (clk),
        .addr   (rom_addr),
        .rd_dat (rom_q)
    );

    // The ROM word is unreset, so every output is gated by the reset-cleared S1 flags.
    assign opaque    = s1_hit && (rom_q != TRANSP_KEY);
    assign color_out = opaque ? rom_q : '0;
    assign out_valid = s1_vld;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Bench for sprite_anim_rom: a looping and a one-shot instance share stimulus and are checked against a behavioural model.
module tb_sprite_anim_rom;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y, pos_x, pos_y;
    logic       pix_valid, vsync_tick, anim_start, anim_stop, flip_h;
    logic [11:0] col_a, col_b;
    logic       opq_a, opq_b, vld_a, vld_b;
    logic [1:0] fr_a, fr_b;

    always #5 clk = ~clk;

    sprite_anim_rom #(.ONE_SHOT(1'b0)) u_loop (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .vsync_tick(vsync_tick), .pos_x(pos_x), .pos_y(pos_y), .anim_start(anim_start),
        .anim_stop(anim_stop), .flip_h(flip_h), .color_out(col_a), .opaque(opq_a),
        .out_valid(vld_a), .frame_idx(fr_a)
    );

    sprite_anim_rom #(.ONE_SHOT(1'b1)) u_once (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .vsync_tick(vsync_tick), .pos_x(pos_x), .pos_y(pos_y), .anim_start(anim_start),
        .anim_stop(anim_stop), .flip_h(flip_h), .color_out(col_b), .opaque(opq_b),
        .out_valid(vld_b), .frame_idx(fr_b)
    );

    int checks = 0;
    int errors = 0;

    // Model state: [0] looping instance, [1] one-shot instance. st: 0 idle, 1 play, 2 hold.
    int m_st [2];
    int m_fr [2];
    int m_tk [2];
    int m_rf [2];
    int m_px, m_py;
    bit m_flip;

    typedef struct {
        logic [11:0] col0;
        logic [11:0] col1;
        logic        opq0;
        logic        opq1;
        logic        vld;
    } exp_t;

    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_fr[i] = 0; m_tk[i] = 0; m_rf[i] = 0;
        end
        m_px = 0; m_py = 0; m_flip = 1'b0;
    endtask

    // Sprite image: word holds {frame, row, column}, except a transparent key at (10,10) and green at (11,10).
    task automatic model_pix(input int fr, input int x, input int y, input bit v,
                             output logic [11:0] col, output logic opq);
        int dx, dy, dxe;
        logic [11:0] w;
        col = '0;
        opq = 1'b0;
        dx = x - m_px;
        dy = y - m_py;
        if (v && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
            dxe = dx;
`ifdef SPRITE_FLIP_EN
            if (m_flip) dxe = 31 - dx;
`endif
            if (dy == 10 && dxe == 10) w = 12'hF0F;
            else if (dy == 10 && dxe == 11) w = 12'h0F0;
            else w = 12'(fr * 1024 + dy * 32 + dxe);
            if (w != 12'hF0F) begin
                opq = 1'b1;
                col = w;
            end
        end
    endtask

    task automatic cyc(input int x, input int y, input bit v, input bit vs, input bit st,
                       input bit sp, input int px, input int py, input bit fl);
        exp_t e;
        @(negedge clk);
        chk("frame_idx_loop", 32'(fr_a), 32'(m_fr[0]));
        chk("frame_idx_once", 32'(fr_b), 32'(m_fr[1]));
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            chk("out_valid", 32'(vld_a), 32'(e.vld));
            chk("opaque_loop", 32'(opq_a), 32'(e.opq0));
            chk("color_loop", 32'(col_a), 32'(e.col0));
            chk("opaque_once", 32'(opq_b), 32'(e.opq1));
            chk("color_once", 32'(col_b), 32'(e.col1));
        end
        pix_x = 10'(x); pix_y = 10'(y); pix_valid = v; vsync_tick = vs;
        anim_start = st; anim_stop = sp; pos_x = 10'(px); pos_y = 10'(py); flip_h = fl;
        model_pix(m_rf[0], x, y, v, e.col0, e.opq0);
        model_pix(m_rf[1], x, y, v, e.col1, e.opq1);
        e.vld = v;
        exp_q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            if (st) begin
                m_st[i] = 1; m_fr[i] = 0; m_tk[i] = 0;
            end else if (sp && m_st[i] != 0) begin
                m_st[i] = 0;
            end else if (m_st[i] == 1 && vs) begin
                m_tk[i]++;
                if (m_tk[i] == 8) begin
                    m_tk[i] = 0;
                    if (m_fr[i] == 3) begin
                        if (i == 1) m_st[i] = 2;
                        else m_fr[i] = 0;
                    end else begin
                        m_fr[i]++;
                    end
                end
            end
            if (vs) m_rf[i] = m_fr[i];
        end
        if (vs) begin
            m_px = px; m_py = py; m_flip = fl;
        end
    endtask

    task automatic pix(input int x, input int y);
        cyc(x, y, 1'b1, 1'b0, 1'b0, 1'b0, int'(pos_x), int'(pos_y), flip_h);
    endtask

    task automatic vsync(input int px, input int py, input bit fl);
        cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, px, py, fl);
    endtask

    task automatic ctl(input bit st, input bit sp, input bit vs);
        cyc(0, 0, 1'b0, vs, st, sp, int'(pos_x), int'(pos_y), flip_h);
    endtask

    function automatic int clip(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic near_pix();
        pix(clip(m_px - 4 + int'($urandom_range(0, 40)), 639),
            clip(m_py - 4 + int'($urandom_range(0, 40)), 479));
    endtask

    initial begin
        rst_n = 1'b0;
        pix_x = '0; pix_y = '0; pix_valid = 1'b0; vsync_tick = 1'b0;
        pos_x = '0; pos_y = '0; anim_start = 1'b0; anim_stop = 1'b0; flip_h = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_color", 32'(col_a), 32'd0);
        chk("rst_opaque", 32'(opq_a), 32'd0);
        chk("rst_valid", 32'(vld_a), 32'd0);
        chk("rst_frame", 32'(fr_a), 32'd0);
        rst_n = 1'b1;

        // Placement, corners, edges and transparency.
        vsync(100, 50, 1'b0);
        pix(100, 50); pix(131, 81); pix(99, 50); pix(132, 50);
        pix(110, 60); pix(111, 60); pix(115, 55); pix(100, 82);

        // Position change mid-frame must not move the sprite until the next vsync.
        cyc(100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 200, 50, 1'b0);
        pix(100, 50); pix(200, 50);
        vsync(200, 50, 1'b0);
        pix(100, 50); pix(200, 50); pix(231, 60);

        // Sprite hanging off the bottom-right corner.
        vsync(630, 470, 1'b0);
        pix(639, 470); pix(0, 470); pix(5, 479); pix(639, 479); pix(629, 470);

        // Mirroring.
        vsync(100, 50, 1'b1);
        pix(100, 50); pix(131, 50); pix(120, 60);
        vsync(100, 50, 1'b0);

        // Idle: vsyncs do not advance.
        repeat (3) begin vsync(100, 50, 1'b0); pix(105, 52); end

        // Play through 40 ticks: loop wraps, one-shot holds the last frame.
        ctl(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            vsync(100, 50, 1'b0);
            pix(100 + int'($urandom_range(0, 31)), 50 + int'($urandom_range(0, 31)));
        end

        // Freeze, then start and stop together, then start coinciding with vsync.
        ctl(1'b0, 1'b1, 1'b0);
        repeat (10) begin vsync(100, 50, 1'b0); pix(100, 50); end
        ctl(1'b1, 1'b1, 1'b0);
        repeat (9) begin vsync(100, 50, 1'b0); pix(131, 81); end
        ctl(1'b1, 1'b0, 1'b1);
        repeat (9) begin vsync(100, 50, 1'b0); pix(110, 60); end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12)
                vsync(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom));
            else if (r < 14)
                ctl(1'b1, 1'b0, 1'b0);
            else if (r < 16)
                ctl(1'b0, 1'b1, 1'b0);
            else if (r < 17)
                ctl(1'b1, 1'b1, 1'b1);
            else
                near_pix();
        end

        // Asynchronous reset mid-line.
        ctl(1'b1, 1'b0, 1'b0);
        vsync(300, 200, 1'b0);
        repeat (4) pix(310, 205);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_color", 32'(col_a), 32'd0);
        chk("arst_opaque", 32'(opq_a), 32'd0);
        chk("arst_valid", 32'(vld_a), 32'd0);
        chk("arst_frame", 32'(fr_a), 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pix(0, 0); pix(5, 3); pix(40, 3);
        repeat (9) begin vsync(0, 0, 1'b0); pix(31, 31); end
        repeat (3) ctl(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
